// File: rtl/fixpoint_accum_requant.sv
// Dot-product accumulator: sums signed Q32.32 products, then rounds, shifts
// and saturates the sum to a Q16.16 result with a valid/ready handoff.
//
// state | meaning
// ACC   | accepting beats, building the sum
// RND   | rounding, shifting and saturating the sum into the output registers
// OUT   | holding the result until downstream takes it
module fixpoint_accum_requant #(
   parameter int FRAC_BITS = 16,
   parameter int ACC_W     = 72
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_prod,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_sat,
   output logic [15:0] out_count
);

   typedef enum logic [1:0] {ACC, RND, OUT} state_t;

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(32'h7FFF_FFFF);
   localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [15:0]             count;
   logic                    first;

   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] rnd_sum;
   logic signed [ACC_W-1:0] r;
   logic [15:0]             count_next;

   assign prod_ext   = ACC_W'($signed(in_prod));
   assign acc_sum    = (first ? '0 : acc) + prod_ext;
   assign rnd_sum    = acc + RND_HALF;
   assign r          = rnd_sum >>> FRAC_BITS;
   assign count_next = first ? 16'd1 : ((count == 16'hFFFF) ? count : count + 16'd1);

   assign in_ready  = (state == ACC);
   assign out_valid = (state == OUT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACC;
         acc       <= '0;
         count     <= '0;
         first     <= 1'b1;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_count <= '0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  acc   <= acc_sum;
                  count <= count_next;
                  first <= 1'b0;
                  if (in_last) state <= RND;
               end
            end
            RND: begin
               if (r > SAT_HI) begin
                  out_data <= 32'h7FFF_FFFF;
                  out_sat  <= 1'b1;
               end else if (r < SAT_LO) begin
                  out_data <= 32'h8000_0000;
                  out_sat  <= 1'b1;
               end else begin
                  out_data <= r[31:0];
                  out_sat  <= 1'b0;
               end
               out_count <= count;
               state     <= OUT;
            end
            OUT: begin
               // Next accepted beat restarts the sum from zero.
               if (out_ready) begin
                  first <= 1'b1;
                  state <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_fixpoint_accum_requant.sv
// Bench for fixpoint_accum_requant: table of packets checked through a result
// scoreboard, plus latency, back-pressure and reset sequences.
module tb_fixpoint_accum_requant;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_prod;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_sat;
   logic [15:0] out_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] prod;
      logic        last;
      int          gap;
      logic [31:0] data;
      logic        sat;
      logic [15:0] cnt;
   } vec_t;

   typedef struct packed {
      logic [31:0] data;
      logic        sat;
      logic [15:0] cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   fixpoint_accum_requant #(.FRAC_BITS(16), .ACC_W(72)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [63:0] prod, input logic last, input int gap,
                          input logic [31:0] data, input logic sat, input logic [15:0] cnt);
      vec_t v;
      v.prod = prod; v.last = last; v.gap = gap;
      v.data = data; v.sat = sat;   v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input logic [31:0] data, input logic sat, input logic [15:0] cnt);
      exp_t e;
      e.data = data; e.sat = sat; e.cnt = cnt;
      sb.push_back(e);
   endtask

   // Drive one beat and return just after the edge that accepts it.
   task automatic send_beat(input logic [63:0] prod, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_prod  = prod;
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("beat_accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk(name, 64'd0, 64'd1);
   endtask

   // Result monitor: every handoff must match the oldest expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("out_data", 64'(out_data), 64'(e.data));
               chk("out_sat", 64'(out_sat), 64'(e.sat));
               chk("out_count", 64'(out_count), 64'(e.cnt));
            end
         end
      end
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Packets: 3 x 1.0; rounding of +/- half LSB; saturation both ways; gaps 0..3.
      add_vec(64'h0000_0001_0000_0000, 1'b0, 0, 32'h0, 1'b0, 16'd0);
      add_vec(64'h0000_0001_0000_0000, 1'b0, 0, 32'h0, 1'b0, 16'd0);
      add_vec(64'h0000_0001_0000_0000, 1'b1, 0, 32'h0003_0000, 1'b0, 16'd3);
      add_vec(64'h0000_0000_0000_8000, 1'b1, 0, 32'h0000_0001, 1'b0, 16'd1);
      add_vec(64'hFFFF_FFFF_FFFF_8000, 1'b1, 0, 32'h0000_0000, 1'b0, 16'd1);
      add_vec(64'hFFFF_FFFF_FFFF_7FFF, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 16'd1);
      add_vec(64'h7FFF_FFFF_0000_0000, 1'b0, 0, 32'h0, 1'b0, 16'd0);
      add_vec(64'h7FFF_FFFF_0000_0000, 1'b1, 0, 32'h7FFF_FFFF, 1'b1, 16'd2);
      add_vec(64'h8000_0000_0000_0000, 1'b0, 0, 32'h0, 1'b0, 16'd0);
      add_vec(64'h8000_0000_0000_0000, 1'b1, 0, 32'h8000_0000, 1'b1, 16'd2);
      add_vec(64'h0000_0001_0000_0000, 1'b0, 0, 32'h0, 1'b0, 16'd0);
      add_vec(64'h0000_0001_0000_0000, 1'b0, 1, 32'h0, 1'b0, 16'd0);
      add_vec(64'h0000_0001_0000_0000, 1'b0, 2, 32'h0, 1'b0, 16'd0);
      add_vec(64'h0000_0001_0000_0000, 1'b1, 3, 32'h0004_0000, 1'b0, 16'd4);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_sat", 64'(out_sat), 64'd0);
      chk("rst_out_count", 64'(out_count), 64'd0);

      foreach (vecs[i]) begin
         repeat (vecs[i].gap) @(posedge clk);
         if (vecs[i].last) push_exp(vecs[i].data, vecs[i].sat, vecs[i].cnt);
         send_beat(vecs[i].prod, vecs[i].last);
      end

      // Latency: RND for one cycle, OUT for one cycle, then back to ACC.
      push_exp(32'h0001_0000, 1'b0, 16'd1);
      send_beat(64'h0000_0001_0000_0000, 1'b1);
      @(negedge clk);
      chk("lat_rnd_out_valid", 64'(out_valid), 64'd0);
      chk("lat_rnd_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("lat_out_valid", 64'(out_valid), 64'd1);
      chk("lat_out_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("lat_back_in_ready", 64'(in_ready), 64'd1);

      // Back-pressure: result held while out_ready is low, pending beat not taken.
      out_ready = 1'b0;
      push_exp(32'h0003_0000, 1'b0, 16'd1);
      send_beat(64'h0000_0003_0000_0000, 1'b1);
      wait_out_valid("hold_out_valid_timeout");
      in_valid = 1'b1;
      in_prod  = 64'h0000_0002_0000_0000;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_out_data", 64'(out_data), 64'h0003_0000);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_out_valid", 64'(out_valid), 64'd1);
      end
      push_exp(32'h0002_0000, 1'b0, 16'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      send_beat(64'h0000_0002_0000_0000, 1'b1);

      // Reset mid-packet discards the partial sum.
      send_beat(64'h0000_0005_0000_0000, 1'b0);
      send_beat(64'h0000_0005_0000_0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      push_exp(32'h0002_0000, 1'b0, 16'd1);
      send_beat(64'h0000_0002_0000_0000, 1'b1);

      // Reset while holding a result drops it.
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      send_beat(64'h0000_0007_0000_0000, 1'b1);
      wait_out_valid("outrst_out_valid_timeout");
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("outrst_out_valid", 64'(out_valid), 64'd0);
      chk("outrst_out_data", 64'(out_data), 64'd0);
      chk("outrst_out_count", 64'(out_count), 64'd0);
      push_exp(32'h0000_8000, 1'b0, 16'd1);
      send_beat(64'h0000_0000_8000_0000, 1'b1);

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
